// File: rtl/mtx_sched.sv
// Phase-stream scheduler: accumulates per-symbol phase increments and streams
// phase words over AXI-stream, SPS samples per symbol, NSYMB symbols per frame.
module mtx_sched #(
  parameter int unsigned PHASE_WIDTH  = 24,
  parameter int unsigned NSYMB_WIDTH  = 16,
  parameter int unsigned NSYMB        = 16,
  parameter int unsigned NFRAME_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [NSYMB_WIDTH-1:0]  cfg_addr,
  input  logic [PHASE_WIDTH-1:0]  cfg_inc,
  input  logic [NSYMB_WIDTH-1:0]  cfg_sps,
  input  logic [NFRAME_WIDTH-1:0] cfg_nframes,
  input  logic                    start,
  input  logic                    stop,
  output logic [PHASE_WIDTH-1:0]  phase_tdata,
  output logic                    phase_tvalid,
  output logic                    phase_tlast,
  input  logic                    phase_tready,
  output logic [NSYMB_WIDTH-1:0]  symb_idx,
  output logic [NSYMB_WIDTH-1:0]  samp_idx,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int unsigned AW = (NSYMB > 1) ? $clog2(NSYMB) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [NSYMB_WIDTH-1:0] LAST_SYMB = NSYMB_WIDTH'(NSYMB - 1);

  logic [0:0]              state, nxt_state;
  logic [PHASE_WIDTH-1:0]  acc, nxt_acc;
  logic [NSYMB_WIDTH-1:0]  nxt_symb, nxt_samp;
  logic [NSYMB_WIDTH-1:0]  sps_q, nxt_sps;
  logic [NFRAME_WIDTH-1:0] nframes_q, nxt_nframes;
  logic [NFRAME_WIDTH-1:0] frame_cnt, nxt_frame, frame_inc;
  logic                    stop_pend, nxt_stop;
  logic                    tlast_q, nxt_last;
  logic                    nxt_done;
  logic                    accept;
  logic [PHASE_WIDTH-1:0]  cur_inc;
  logic [PHASE_WIDTH-1:0]  tbl [NSYMB];

  assign accept       = (state == RUN) && phase_tready;
  assign cur_inc      = tbl[symb_idx[AW-1:0]];
  assign phase_tdata  = acc;
  assign phase_tvalid = (state == RUN);
  assign busy         = (state == RUN);
  assign phase_tlast  = tlast_q;

  // Increment table; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NSYMB; i++) tbl[i] <= '0;
    end else if (cfg_we && (32'(cfg_addr) < NSYMB)) begin
      tbl[cfg_addr[AW-1:0]] <= cfg_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      acc        <= '0;
      symb_idx   <= '0;
      samp_idx   <= '0;
      sps_q      <= NSYMB_WIDTH'(1);
      nframes_q  <= '0;
      frame_cnt  <= '0;
      stop_pend  <= 1'b0;
      tlast_q    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      acc        <= nxt_acc;
      symb_idx   <= nxt_symb;
      samp_idx   <= nxt_samp;
      sps_q      <= nxt_sps;
      nframes_q  <= nxt_nframes;
      frame_cnt  <= nxt_frame;
      stop_pend  <= nxt_stop;
      tlast_q    <= nxt_last;
      frame_done <= nxt_done;
    end
  end

  // Next-state and counter logic; tlast is precomputed from next indices.
  always_comb begin
    nxt_state   = state;
    nxt_acc     = acc;
    nxt_symb    = symb_idx;
    nxt_samp    = samp_idx;
    nxt_sps     = sps_q;
    nxt_nframes = nframes_q;
    nxt_frame   = frame_cnt;
    nxt_stop    = stop_pend;
    nxt_done    = 1'b0;
    frame_inc   = frame_cnt + NFRAME_WIDTH'(1);
    case (state)
      IDLE: begin
        if (start) begin
          nxt_state   = RUN;
          nxt_sps     = (cfg_sps == '0) ? NSYMB_WIDTH'(1) : cfg_sps;
          nxt_nframes = cfg_nframes;
          nxt_acc     = '0;
          nxt_symb    = '0;
          nxt_samp    = '0;
          nxt_frame   = '0;
          nxt_stop    = 1'b0;
        end
      end
      RUN: begin
        if (stop) nxt_stop = 1'b1;
        if (accept) begin
          nxt_acc = acc + cur_inc;
          if (samp_idx == sps_q - NSYMB_WIDTH'(1)) begin
            nxt_samp = '0;
            if (symb_idx == LAST_SYMB) begin
              nxt_symb  = '0;
              nxt_acc   = '0;
              nxt_frame = frame_inc;
              if (((nframes_q != '0) && (frame_inc == nframes_q)) || stop_pend || stop) begin
                nxt_state = IDLE;
                nxt_done  = 1'b1;
              end
            end else begin
              nxt_symb = symb_idx + NSYMB_WIDTH'(1);
            end
          end else begin
            nxt_samp = samp_idx + NSYMB_WIDTH'(1);
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
    nxt_last = (nxt_state == RUN) && (nxt_symb == LAST_SYMB) &&
               (nxt_samp == nxt_sps - NSYMB_WIDTH'(1));
  end

endmodule
